// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator
// Description : Sums a valid/ready stream of 16-bit unsigned products into an
//               ACC_W-bit accumulator until a beat marked last arrives. It then
//               holds the sum, the saturating beat count and the sticky
//               overflow flag on the result port until the consumer accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  // The sum is formed one bit wider than the accumulator so the carry out of
  // the top bit can be caught; an exact 2^ACC_W wraps to zero with ovf set.
  assign w_accept  = prod_valid & prod_ready;
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W+1-16){1'b0}}, prod_in};
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

  // Next-state decode and state-only handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    prod_ready  = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        prod_ready = 1'b1;
        if (w_accept) w_state_nxt = prod_last ? S_DONE : S_ACC;
      end
      S_ACC: begin
        prod_ready = 1'b1;
        if (w_accept && prod_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Accumulator datapath: the first beat of a group loads, later beats add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc <= {{(ACC_W-16){1'b0}}, prod_in};
        r_cnt <= C_CNT_ONE;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
    end
  end

  assign acc_out   = r_acc;
  assign acc_count = r_cnt;
  assign acc_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Directed bench for mac_accumulator. Two instances share the
//               same stimulus: one with default widths, one with ACC_W=17 and
//               CNT_W=2 to reach wrap-around and counter saturation. Expected
//               results are queued as groups are driven and compared when the
//               result port presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

  logic        clk;
  logic        rst;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        prod_last;
  logic        out_ready;

  logic        d_prod_ready, d_acc_ovf, d_out_valid;
  logic [23:0] d_acc_out;
  logic [7:0]  d_acc_count;
  logic        s_prod_ready, s_acc_ovf, s_out_valid;
  logic [16:0] s_acc_out;
  logic [1:0]  s_acc_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint acc_d; longint cnt_d; longint ovf_d;
    longint acc_s; longint cnt_s; longint ovf_s;
  } exp_t;
  exp_t sb[$];

  mac_accumulator u_def (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(d_prod_ready), .acc_out(d_acc_out),
    .acc_count(d_acc_count), .acc_ovf(d_acc_ovf), .out_valid(d_out_valid),
    .out_ready(out_ready)
  );

  mac_accumulator #(.ACC_W(17), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(s_prod_ready), .acc_out(s_acc_out),
    .acc_count(s_acc_count), .acc_ovf(s_acc_ovf), .out_valid(s_out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: all beats are non-negative, so the sticky overflow is
  // equivalent to the true total reaching 2^ACC_W.
  task automatic expect_group(input longint sum, input longint n);
    exp_t e;
    e.acc_d = sum % (64'd1 << 24);
    e.ovf_d = (sum >= (64'd1 << 24)) ? 1 : 0;
    e.cnt_d = (n > 255) ? 255 : n;
    e.acc_s = sum % (64'd1 << 17);
    e.ovf_s = (sum >= (64'd1 << 17)) ? 1 : 0;
    e.cnt_s = (n > 3) ? 3 : n;
    sb.push_back(e);
  endtask

  // Drive one beat (called just after an edge) and hold it until accepted.
  task automatic beat(input logic [15:0] v, input logic last, input int gap);
    bit got;
    got        = 1'b0;
    prod_in    = v;
    prod_valid = 1'b1;
    prod_last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_prod_ready) begin
        @(posedge clk);
        got = 1'b1;
        break;
      end
    end
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    chk("beat_accepted", got, 1);
    chk("def_valid_after_beat", d_out_valid, last);
    chk("small_valid_after_beat", s_out_valid, last);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_result(input exp_t e, input string tag);
    chk({tag, "_def_acc"}, d_acc_out, e.acc_d);
    chk({tag, "_def_cnt"}, d_acc_count, e.cnt_d);
    chk({tag, "_def_ovf"}, d_acc_ovf, e.ovf_d);
    chk({tag, "_small_acc"}, s_acc_out, e.acc_s);
    chk({tag, "_small_cnt"}, s_acc_count, e.cnt_s);
    chk({tag, "_small_ovf"}, s_acc_ovf, e.ovf_s);
    chk({tag, "_ready_low"}, d_prod_ready, 0);
    chk({tag, "_small_ready_low"}, s_prod_ready, 0);
  endtask

  // Compare the presented result, optionally stall the consumer, then accept.
  task automatic collect(input int hold);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (d_out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("out_valid_seen", ok, 1);
    chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_result(e, "result");
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        prod_in    = 16'd999;
        prod_valid = 1'b1;
        prod_last  = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_valid", d_out_valid, 1);
        check_result(e, "hold");
      end
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_fall", d_out_valid, 0);
      chk("small_valid_fall", s_out_valid, 0);
      chk("ready_rise", d_prod_ready, 1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    out_ready  = 1'b0;
    #2;
    chk("rst_acc", d_acc_out, 0);
    chk("rst_cnt", d_acc_count, 0);
    chk("rst_ovf", d_acc_ovf, 0);
    chk("rst_valid", d_out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", d_prod_ready, 1);
    @(posedge clk);
    #1;

    // Basic pair 8 + 160.
    expect_group(168, 2);
    beat(16'd8, 1'b0, 0);
    beat(16'd160, 1'b1, 0);
    collect(0);

    // Single beat 255*255; DONE lasts exactly one cycle.
    expect_group(65025, 1);
    beat(16'd65025, 1'b1, 0);
    collect(0);

    // Backpressure with junk beats offered while DONE.
    expect_group(300, 2);
    beat(16'd100, 1'b0, 0);
    beat(16'd200, 1'b1, 0);
    collect(5);

    // Just below the 17-bit limit, then exactly 2^17.
    expect_group(131070, 2);
    beat(16'hFFFF, 1'b0, 0);
    beat(16'hFFFF, 1'b1, 0);
    collect(0);
    expect_group(131072, 3);
    beat(16'hFFFF, 1'b0, 0);
    beat(16'hFFFF, 1'b0, 0);
    beat(16'd2, 1'b1, 0);
    collect(0);

    // Bubbles between beats and counter saturation.
    expect_group(5, 5);
    for (int i = 0; i < 4; i++) beat(16'd1, 1'b0, 2);
    beat(16'd1, 1'b1, 0);
    collect(0);

    // Reset between edges mid-group discards the partial sum.
    beat(16'd50, 1'b0, 0);
    beat(16'd60, 1'b0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_acc", d_acc_out, 0);
    chk("midrst_cnt", d_acc_count, 0);
    chk("midrst_small_acc", s_acc_out, 0);
    chk("midrst_valid", d_out_valid, 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", d_prod_ready, 1);
    chk("post_rst_valid", d_out_valid, 0);
    expect_group(7, 1);
    beat(16'd7, 1'b1, 0);
    collect(0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
